// File: rtl/picoblaze_io_bank.sv
// KCPSM6 port I/O bank: output registers, input read mux, latched event flags with mask and IRQ handshake.
// Latency: writes land on the strobe edge, reads and interrupt are registered (1 cycle); no backpressure.
module picoblaze_io_bank #(
  parameter int                DATA_W      = 8,
  parameter int                N_OUT       = 4,
  parameter int                N_IN        = 4,
  parameter logic [7:0]        STATUS_ADDR = 8'hF0,
  parameter logic [7:0]        MASK_ADDR   = 8'hF1,
  parameter logic [DATA_W-1:0] OUT_RST     = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                port_id,
  input  logic [DATA_W-1:0]         out_port,
  input  logic                      write_strobe,
  input  logic                      k_write_strobe,
  input  logic                      read_strobe,
  output logic [DATA_W-1:0]         in_port,
  input  logic [N_IN*DATA_W-1:0]    in_bus,
  input  logic [N_IN-1:0]           in_event,
  output logic [N_OUT*DATA_W-1:0]   out_bus,
  output logic [N_OUT-1:0]          out_wr_pulse,
  output logic                      interrupt,
  input  logic                      interrupt_ack
);

  localparam int MAX_N = (N_IN > N_OUT) ? N_IN : N_OUT;

  if (int'(STATUS_ADDR) < MAX_N || int'(MASK_ADDR) < MAX_N || STATUS_ADDR == MASK_ADDR) begin : g_bad_addr
    $error("picoblaze_io_bank: STATUS_ADDR/MASK_ADDR must be distinct and above the port range");
  end
  if (N_IN < 1 || N_IN > DATA_W) begin : g_bad_n_in
    $error("picoblaze_io_bank: N_IN must be 1..DATA_W");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
    $error("picoblaze_io_bank: N_OUT must be 1..16");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} irq_state_t;

  logic [1:0]                    rst_sync;
  logic                          rst_n;
  logic [N_OUT-1:0][DATA_W-1:0]  out_q;
  logic [N_OUT-1:0]              wr_sel;
  logic                          mask_wr;
  logic [N_IN-1:0]               clr;
  logic [N_IN-1:0]               flags;
  logic [N_IN-1:0]               mask;
  logic [N_IN-1:0]               ev_d;
  logic [N_IN-1:0]               rise;
  logic                          pend;
  logic [DATA_W-1:0]             rd_dat;
  irq_state_t                    state, state_nxt;
  logic                          unused_rd;

  assign unused_rd = read_strobe;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // write_strobe has priority; the K strobe only reaches the output registers.
  always_comb begin
    wr_sel  = '0;
    mask_wr = 1'b0;
    clr     = '0;
    if (write_strobe) begin
      for (int j = 0; j < N_OUT; j++)
        if (port_id == 8'(j)) wr_sel[j] = 1'b1;
      if (port_id == MASK_ADDR)   mask_wr = 1'b1;
      if (port_id == STATUS_ADDR) clr = out_port[N_IN-1:0];
    end else if (k_write_strobe) begin
      for (int j = 0; j < N_OUT; j++)
        if (port_id[3:0] == 4'(j)) wr_sel[j] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= {N_OUT{OUT_RST}};
      out_wr_pulse <= '0;
      mask         <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++)
        if (wr_sel[j]) out_q[j] <= out_port;
      out_wr_pulse <= wr_sel;
      if (mask_wr) mask <= out_port[N_IN-1:0];
    end
  end
  assign out_bus = out_q;

  // A rising edge beats a same-cycle write-1-to-clear.
  assign rise = in_event & ~ev_d;
  assign pend = |(flags & mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_d  <= '0;
      flags <= '0;
    end else begin
      ev_d  <= in_event;
      flags <= (flags & ~clr) | rise;
    end
  end

  always_comb begin
    rd_dat = '0;
    if (port_id == STATUS_ADDR) begin
      rd_dat[N_IN-1:0] = flags;
    end else if (port_id == MASK_ADDR) begin
      rd_dat[N_IN-1:0] = mask;
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (port_id == 8'(i)) rd_dat = in_bus[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_port <= '0;
    else        in_port <= rd_dat;
  end

  // Once asserted, only an ack releases the request, even if the mask drops.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pend)          state_nxt = ST_ASSERT;
      ST_ASSERT:  if (interrupt_ack) state_nxt = ST_SERVICE;
      ST_SERVICE: if (!pend)         state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nxt;
      interrupt <= (state_nxt == ST_ASSERT);
    end
  end

endmodule
